// File: rtl/sp_arith_pkg.sv
// sp_arith_pkg -- shared definitions for the pipelined adder/subtractor.
//   OP_ADD / OP_SUB : encoding of the per-transaction 'sub' input
//   flags_t         : {carry, ovf} flag pair carried down the pipeline
//   sat_max/sat_min : clamp values for a given width and signedness,
//                     returned right-aligned in 64 bits (width <= 64)
package sp_arith_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic carry;
    logic ovf;
  } flags_t;

  // Largest representable value: 2^(w-1)-1 signed, 2^w-1 unsigned.
  function automatic logic [63:0] sat_max(input int width, input bit is_signed);
    logic [63:0] ones;
    ones = '1;
    if (is_signed) return ones >> (65 - width);
    else           return ones >> (64 - width);
  endfunction

  // Smallest representable value as a WIDTH-bit pattern: -2^(w-1) signed, 0 unsigned.
  function automatic logic [63:0] sat_min(input int width, input bit is_signed);
    if (is_signed) return 64'd1 << (width - 1);
    else           return 64'd0;
  endfunction

endpackage

// File: rtl/sp_ce_delay_line.sv
// sp_ce_delay_line -- generic clock-enabled register chain with async reset.
//   clk, rst : clock and asynchronous active-high reset (clears every stage)
//   ce       : 1 shifts the chain one place, 0 holds every stage
//   d        : word entering stage 0
//   q        : word leaving the last stage (DEPTH ce-active edges after d)
//   msb_any  : OR of the top bit of every stage; callers that keep a valid
//              flag in the MSB get an "anything in flight" indication
module sp_ce_delay_line #(
  parameter int DEPTH = 1,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         msb_any
);

  logic [W-1:0] regs [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (ce) begin
      regs[0] <= d;
      for (int i = 1; i < DEPTH; i++) regs[i] <= regs[i-1];
    end
  end

  assign q = regs[DEPTH-1];

  always_comb begin
    msb_any = 1'b0;
    for (int i = 0; i < DEPTH; i++) msb_any = msb_any | regs[i][W-1];
  end

endmodule

// File: rtl/sp_addsub_pipe.sv
// sp_addsub_pipe -- parametrised pipelined adder/subtractor.
//   clk, rst   : clock (rising edge) and asynchronous active-high reset
//   ce         : clock enable; 0 freezes every pipeline register
//   in_valid   : operands valid (sampled only on ce=1 edges)
//   sub        : 0 = A+B, 1 = A-B, sampled with in_valid
//   A, B       : WIDTH-bit operands
//   out_valid  : S/carry/ovf hold a result
//   S          : result (wrapped or saturated)
//   carry      : unsigned carry-out / borrow; 0 when SIGNED=1
//   ovf        : raw overflow before saturation (signed overflow or
//                unsigned carry/borrow)
//   busy       : some pipeline stage holds a valid transaction
//
// Handshake: valid-only, no back-pressure. A transaction is taken on every
// ce=1 edge where in_valid=1; it emerges with out_valid=1 after LATENCY
// ce-active edges (the accepting edge counts as the first). Consumers must
// qualify S/carry/ovf with out_valid; when out_valid=0 they hold stale data.
//
// The arithmetic is resolved in stage 0; the remaining LATENCY-1 stages are
// a plain delay line over the {valid, flags, S} bundle.
module sp_addsub_pipe
  import sp_arith_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int LATENCY  = 2,
  parameter int SIGNED   = 0,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             in_valid,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  output logic [WIDTH-1:0] S,
  output logic             carry,
  output logic             ovf,
  output logic             busy
);

  // Bundle layout, MSB first: {valid, carry, ovf, S}
  localparam int BW = WIDTH + 3;

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(sat_max(WIDTH, SIGNED != 0));
  localparam logic [WIDTH-1:0] MIN_V = WIDTH'(sat_min(WIDTH, SIGNED != 0));

  logic             is_sub;
  logic [WIDTH:0]   raw;
  logic             sovf;
  flags_t           f_nxt;
  logic [WIDTH-1:0] s_nxt;

  always_comb begin
    is_sub = (sub == OP_SUB);
    raw    = is_sub ? ({1'b0, A} - {1'b0, B}) : ({1'b0, A} + {1'b0, B});
    // Signed overflow: the operation could only overflow if the effective
    // operand signs agree, and it did if the result sign left A's sign.
    if (is_sub) sovf = (A[WIDTH-1] != B[WIDTH-1]) && (raw[WIDTH-1] != A[WIDTH-1]);
    else        sovf = (A[WIDTH-1] == B[WIDTH-1]) && (raw[WIDTH-1] != A[WIDTH-1]);
    // For subtraction bit WIDTH of the extended difference is the borrow (A<B).
    f_nxt.carry = (SIGNED == 0) ? raw[WIDTH] : 1'b0;
    f_nxt.ovf   = (SIGNED != 0) ? sovf : raw[WIDTH];
    s_nxt       = raw[WIDTH-1:0];
    if ((SATURATE != 0) && f_nxt.ovf) begin
      // Signed: direction follows A's sign. Unsigned: add can only go over
      // the top, sub can only go under zero.
      if (SIGNED != 0) s_nxt = A[WIDTH-1] ? MIN_V : MAX_V;
      else             s_nxt = is_sub ? MIN_V : MAX_V;
    end
  end

  // Stage 0: captures operands' result every ce edge regardless of in_valid;
  // the valid bit alone decides whether it ever counts.
  logic [BW-1:0] s0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     s0 <= '0;
    else if (ce) s0 <= {in_valid, f_nxt, s_nxt};
  end

  logic [BW-1:0] last;

  if (LATENCY == 1) begin : g_direct
    assign last = s0;
    assign busy = s0[BW-1];
  end else begin : g_delay
    logic dl_busy;

    sp_ce_delay_line #(
      .DEPTH (LATENCY - 1),
      .W     (BW)
    ) u_delay (
      .clk     (clk),
      .rst     (rst),
      .ce      (ce),
      .d       (s0),
      .q       (last),
      .msb_any (dl_busy)
    );

    assign busy = s0[BW-1] | dl_busy;
  end

  flags_t out_f;

  assign out_valid = last[BW-1];
  assign out_f     = last[WIDTH+1:WIDTH];
  assign carry     = out_f.carry;
  assign ovf       = out_f.ovf;
  assign S         = last[WIDTH-1:0];

endmodule
